// File: rtl/mix_columns_seq.sv
// -----------------------------------------------------------------------------
// mix_columns_seq
//
// Sequential AES MixColumns (forward/encryption direction). A 128-bit state
// is accepted in IDLE and copied into a working register. The block then
// spends four cycles in BUSY, replacing one 32-bit column per cycle with its
// mixed value, and presents the result in DONE until it is accepted.
// A block flagged as the final AES round (last_round, when PASS_LAST is set)
// still takes the same four BUSY cycles, but its columns are left unchanged.
//
// State layout: column c is in_state[127-32c -: 32], and byte 0 of a column
// is in its MSBs.
//
// Parameters
//   PASS_LAST   1: last_round selects bypass. 0: last_round is ignored.
//
// Ports
//   clk         clock; every state change happens on its rising edge
//   rst_n       asynchronous active-low reset
//   clear       synchronous abort to IDLE (working register is kept)
//   in_valid    input block valid
//   in_ready    high in IDLE only
//   in_state    128-bit input state
//   last_round  sampled together with in_state; requests bypass
//   out_valid   high in DONE only
//   out_ready   downstream accepts the result
//   out_state   working register; meaningful only while out_valid is high
// -----------------------------------------------------------------------------
//  state | meaning
//  IDLE  | waiting for in_valid; in_ready high
//  BUSY  | processing column col (0..3), one column per cycle
//  DONE  | result held on out_state with out_valid high until out_ready
// -----------------------------------------------------------------------------
module mix_columns_seq #(
  parameter bit PASS_LAST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [1:0]   col_q,   col_d;
  logic [127:0] work_q,  work_d;
  logic         bypass_q, bypass_d;

  logic [31:0]  col_cur;
  logic [31:0]  col_mix;

  // GF(2^8) multiply by 2, reduced by the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    mul3 = xtime(x) ^ x;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] s);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] r0, r1, r2, r3;
    s0 = s[31:24];
    s1 = s[23:16];
    s2 = s[15:8];
    s3 = s[7:0];
    r0 = xtime(s0) ^ mul3(s1)  ^ s2        ^ s3;
    r1 = s0        ^ xtime(s1) ^ mul3(s2)  ^ s3;
    r2 = s0        ^ s1        ^ xtime(s2) ^ mul3(s3);
    r3 = mul3(s0)  ^ s1        ^ s2        ^ xtime(s3);
    mix_column = {r0, r1, r2, r3};
  endfunction

  // Column currently addressed by col; column 0 lives in the MSBs.
  always_comb begin
    col_cur = work_q[127:96];
    case (col_q)
      2'd0:    col_cur = work_q[127:96];
      2'd1:    col_cur = work_q[95:64];
      2'd2:    col_cur = work_q[63:32];
      default: col_cur = work_q[31:0];
    endcase
  end

  assign col_mix = mix_column(col_cur);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    work_d   = work_q;
    bypass_d = bypass_q;

    if (clear) begin
      // Abort wins over every transfer; work_q is deliberately kept.
      state_d = IDLE;
      col_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_d   = in_state;
            bypass_d = last_round & PASS_LAST;
            col_d    = 2'd0;
            state_d  = BUSY;
          end
        end

        BUSY: begin
          // Bypass blocks still walk all four columns so that mix and
          // bypass blocks share the same latency.
          if (!bypass_q) begin
            case (col_q)
              2'd0:    work_d[127:96] = col_mix;
              2'd1:    work_d[95:64]  = col_mix;
              2'd2:    work_d[63:32]  = col_mix;
              default: work_d[31:0]   = col_mix;
            endcase
          end
          col_d = col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_d = DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
          col_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      col_q    <= 2'd0;
      work_q   <= 128'h0;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      work_q   <= work_d;
      bypass_q <= bypass_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic [127:0] in_state;
  logic         last_round;
  logic         out_ready;

  logic         in_ready_a,  out_valid_a;
  logic [127:0] out_state_a;
  logic         in_ready_b,  out_valid_b;
  logic [127:0] out_state_b;

  int checks = 0;
  int errors = 0;

  // dut_a honours last_round, dut_b always mixes; both see the same stimulus.
  mix_columns_seq #(.PASS_LAST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_state(in_state),
    .last_round(last_round), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_state(out_state_a)
  );

  mix_columns_seq #(.PASS_LAST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_state(in_state),
    .last_round(last_round), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_state(out_state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Carry-less polynomial product followed by long division by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Circulant MixColumns matrix: row r is (2,3,1,1) rotated right by r.
  function automatic logic [7:0] coef(input int r, input int k);
    case ((k - r + 4) % 4)
      0: return 8'd2;
      1: return 8'd3;
      default: return 8'd1;
    endcase
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input bit bypass);
    logic [127:0] r;
    logic [7:0]   acc;
    if (bypass) return s;
    r = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef(row, k), s[127 - 32*c - 8*k -: 8]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    return r;
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] garbage();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the negedge after E0.
  // in_valid stays high with junk data during BUSY, which must be ignored.
  task automatic start_block(input logic [127:0] s, input logic lr);
    chk1("in_ready_idle", in_ready_a, 1'b1);
    in_valid   = 1'b1;
    in_state   = s;
    last_round = lr;
    @(posedge clk);
    @(negedge clk);
    in_state   = garbage();
    last_round = ~lr;
  endtask

  task automatic wait_done();
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) chk1("latency_early", out_valid_a, 1'b0);
      if (k == 4) chk1("latency_e4", out_valid_a, 1'b1);
    end
  endtask

  task automatic finish_block(input logic [127:0] exp_a, input logic [127:0] exp_b,
                              input int hold);
    chk128("out_state_a", out_state_a, exp_a);
    chk128("out_state_b", out_state_b, exp_b);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk1("hold_valid", out_valid_a, 1'b1);
      chk128("hold_state", out_state_a, exp_a);
      chk1("hold_in_ready", in_ready_a, 1'b0);
    end
    // A new block offered on the handshake edge must not be taken.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = garbage();
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk1("post_hs_in_ready", in_ready_a, 1'b1);
    chk1("post_hs_out_valid", out_valid_a, 1'b0);
  endtask

  task automatic run_block(input logic [127:0] s, input logic lr,
                           input logic [127:0] exp_a, input logic [127:0] exp_b,
                           input int hold);
    start_block(s, lr);
    wait_done();
    finish_block(exp_a, exp_b, hold);
  endtask

  typedef struct {
    logic [127:0] din;
    logic         lr;
    logic [127:0] exp_a;
    logic [127:0] exp_b;
  } vec_t;

  vec_t vecs[4];

  localparam logic [127:0] V1_IN  = 128'hdb135345_00000000_00000000_00000000;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_00000000_00000000_00000000;
  localparam logic [127:0] V2_IN  = 128'hd4bf5d30_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_OUT = 128'h046681e5_9fdc589d_01010101_c6c6c6c6;

  initial begin
    logic [127:0] s;
    logic         lr;

    vecs[0] = '{V1_IN, 1'b0, V1_OUT, V1_OUT};
    vecs[1] = '{V2_IN, 1'b0, V2_OUT, V2_OUT};
    vecs[2] = '{V2_IN, 1'b1, V2_IN,  V2_OUT};
    vecs[3] = '{V1_IN, 1'b1, V1_IN,  V1_OUT};

    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_state   = 128'h0;
    last_round = 1'b0;
    out_ready  = 1'b0;

    // Reset state, with in_valid offered while in reset.
    @(negedge clk);
    in_valid = 1'b1;
    in_state = V2_IN;
    @(negedge clk);
    chk1("rst_in_ready", in_ready_a, 1'b1);
    chk1("rst_out_valid", out_valid_a, 1'b0);
    chk128("rst_out_state", out_state_a, 128'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Table vectors; the first transfer happens on the first edge after release.
    for (int i = 0; i < 4; i++)
      run_block(vecs[i].din, vecs[i].lr, vecs[i].exp_a, vecs[i].exp_b, 0);

    // Long back-pressure in DONE.
    run_block(V2_IN, 1'b0, V2_OUT, V2_OUT, 10);

    // Randomized blocks against the model.
    for (int n = 0; n < 20; n++) begin
      s  = garbage();
      lr = 1'($urandom_range(0, 1));
      run_block(s, lr, model(s, lr), model(s, 1'b0), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-BUSY (after col reached 2).
    start_block(V2_IN, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk1("arst_out_valid", out_valid_a, 1'b0);
    chk128("arst_out_state", out_state_a, 128'h0);
    chk1("arst_in_ready", in_ready_a, 1'b1);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    run_block(V1_IN, 1'b0, V1_OUT, V1_OUT, 1);

    // clear in BUSY, then a new block on the very next edge.
    start_block(V2_IN, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk1("clr_busy_in_ready", in_ready_a, 1'b1);
    chk1("clr_busy_out_valid", out_valid_a, 1'b0);
    run_block(V2_IN, 1'b1, V2_IN, V2_OUT, 0);

    // clear on the same edge as the output handshake, then clear vs. input.
    start_block(V1_IN, 1'b0);
    wait_done();
    out_ready = 1'b1;
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_state  = V2_IN;
    @(posedge clk);
    @(negedge clk);
    chk1("clr_hs_out_valid", out_valid_a, 1'b0);
    chk1("clr_hs_in_ready", in_ready_a, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk1("clr_blocks_xfer", in_ready_a, 1'b1);
    clear     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    s = garbage();
    run_block(s, 1'b0, model(s, 1'b0), model(s, 1'b0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
